// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store, data first with a starvation guard.
// Define ARB_PERF_CNT_EN to add the stall_cnt_o / conflict_cnt_o performance counters.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ireq_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic [DATA_W-1:0] irdata_o,
  output logic              iack_o,
  input  logic              dreq_i,
  input  logic              dwe_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic [DATA_W-1:0] dwdata_i,
  output logic [DATA_W-1:0] drdata_o,
  output logic              dack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [15:0]       conflict_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } arbStateT;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arbStateT          stateReg, stateNext;
  logic [3:0]        starveCntReg, starveCntNext;
  logic              memEnNext, memWeNext, iackNext, dackNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWdataNext, irdataNext, drdataNext;
  logic              grantData;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateReg     <= IDLE;
      starveCntReg <= '0;
      mem_en_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      irdata_o     <= '0;
      drdata_o     <= '0;
      iack_o       <= 1'b0;
      dack_o       <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      starveCntReg <= starveCntNext;
      mem_en_o     <= memEnNext;
      mem_we_o     <= memWeNext;
      mem_addr_o   <= memAddrNext;
      mem_wdata_o  <= memWdataNext;
      irdata_o     <= irdataNext;
      drdata_o     <= drdataNext;
      iack_o       <= iackNext;
      dack_o       <= dackNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    starveCntNext = starveCntReg;
    memEnNext     = mem_en_o;
    memWeNext     = mem_we_o;
    memAddrNext   = mem_addr_o;
    memWdataNext  = mem_wdata_o;
    irdataNext    = irdata_o;
    drdataNext    = drdata_o;
    iackNext      = 1'b0;
    dackNext      = 1'b0;
    // Data wins unless the fetch has already been passed over STARVE_LIMIT times in a row.
    grantData     = dreq_i && !(ireq_i && (starveCntReg == STARVE_MAX));

    case (stateReg)
      IDLE: begin
        if (grantData) begin
          memEnNext    = 1'b1;
          memWeNext    = dwe_i;
          memAddrNext  = daddr_i;
          memWdataNext = dwdata_i;
          stateNext    = DBUSY;
          if (ireq_i) begin
            starveCntNext = (starveCntReg == STARVE_MAX) ? STARVE_MAX : starveCntReg + 4'd1;
          end else begin
            starveCntNext = '0;
          end
        end else if (ireq_i) begin
          memEnNext     = 1'b1;
          memWeNext     = 1'b0;
          memAddrNext   = iaddr_i;
          memWdataNext  = '0;
          stateNext     = IBUSY;
          starveCntNext = '0;
        end
      end
      IBUSY: begin
        if (mem_ack_i) begin
          memEnNext  = 1'b0;
          irdataNext = mem_rdata_i;
          iackNext   = 1'b1;
          stateNext  = RESP;
        end
      end
      DBUSY: begin
        if (mem_ack_i) begin
          memEnNext = 1'b0;
          if (!mem_we_o) begin
            drdataNext = mem_rdata_i;
          end
          dackNext  = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // The ack terms release the stall in the response cycle so the pipeline advances exactly once.
  assign stall_o = ~rst_i & ((dreq_i & ~dack_o) | (ireq_i & ~iack_o));

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o    <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if (stall_o) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if ((stateReg == IDLE) && ireq_i && dreq_i && (conflict_cnt_o != 16'hFFFF)) begin
        conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: background requesters and a memory model, per-scenario tasks.
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i, ireq_i, dreq_i, dwe_i, mem_ack_i;
  logic [31:0] iaddr_i, daddr_i, dwdata_i, mem_rdata_i;
  logic [31:0] irdata_o, drdata_o, mem_addr_o, mem_wdata_o;
  logic        iack_o, dack_o, mem_en_o, mem_we_o, stall_o;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] stallCnt;
  logic [15:0] conflictCnt;
`endif

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ireq_i(ireq_i), .iaddr_i(iaddr_i), .irdata_o(irdata_o), .iack_o(iack_o),
    .dreq_i(dreq_i), .dwe_i(dwe_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i),
    .drdata_o(drdata_o), .dack_o(dack_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o)
`ifdef ARB_PERF_CNT_EN
    , .stall_cnt_o(stallCnt), .conflict_cnt_o(conflictCnt)
`endif
  );

  typedef struct {
    bit          isData;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txnT;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reqT;

  txnT         cmdQ[$];
  txnT         ackQ[$];
  reqT         dReqQ[$];
  logic [31:0] iReqQ[$];
  int          assertCnt = 0;
  int          failCnt   = 0;
  logic [31:0] lastDrdata = 32'h0;
  int          memLat  = 1;
  bit          memAuto = 1'b1;

  function automatic logic [31:0] memVal(input logic [31:0] a);
    if (a == 32'h40) return 32'h2002_0005;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Expected transactions are queued in the order the arbiter must serve them.
  task automatic expect_txn(input bit isData, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    txnT t;
    t.isData = isData;
    t.we     = isData && we;
    t.addr   = addr;
    t.wdata  = isData ? wdata : 32'h0;
    t.rdata  = t.we ? lastDrdata : memVal(addr);
    if (isData && !we) lastDrdata = t.rdata;
    cmdQ.push_back(t);
    ackQ.push_back(t);
  endtask

  // Data requester: holds each request until dack_o, then presents the next one at once.
  initial begin : dRequester
    reqT cur;
    bit  active;
    active = 1'b0;
    forever begin
      @(negedge clk_i);
      if (active && dack_o === 1'b1) begin
        active = 1'b0;
        dreq_i = 1'b0;
      end
      if (!active && dReqQ.size() > 0) begin
        cur      = dReqQ.pop_front();
        dreq_i   = 1'b1;
        dwe_i    = cur.we;
        daddr_i  = cur.addr;
        dwdata_i = cur.wdata;
        active   = 1'b1;
      end
    end
  end

  initial begin : iRequester
    bit active;
    active = 1'b0;
    forever begin
      @(negedge clk_i);
      if (active && iack_o === 1'b1) begin
        active = 1'b0;
        ireq_i = 1'b0;
      end
      if (!active && iReqQ.size() > 0) begin
        iaddr_i = iReqQ.pop_front();
        ireq_i  = 1'b1;
        active  = 1'b1;
      end
    end
  end

  // Memory model: checks each command against the scoreboard every busy cycle, acks after memLat cycles.
  initial begin : memModel
    txnT cur;
    bit  busy;
    int  waitCnt;
    busy    = 1'b0;
    waitCnt = 0;
    forever begin
      @(negedge clk_i);
      if (memAuto) begin
        mem_ack_i = 1'b0;
        if (mem_en_o === 1'b1) begin
          if (!busy) begin
            busy    = 1'b1;
            waitCnt = 0;
            assertCnt++;
            if (cmdQ.size() == 0) begin
              failCnt++;
              $display("FAIL unexpected_cmd: got we=%0b addr=%h, required no command", mem_we_o, mem_addr_o);
              cur.we = mem_we_o; cur.addr = mem_addr_o; cur.wdata = mem_wdata_o;
            end else begin
              cur = cmdQ.pop_front();
            end
            $display("cmd  we=%0b addr=%h wdata=%h lat=%0d", mem_we_o, mem_addr_o, mem_wdata_o, memLat);
          end
          assertCnt++;
          if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {cur.we, cur.addr, cur.wdata})
            begin
            failCnt++;
            $display("FAIL mem_cmd: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                     mem_we_o, mem_addr_o, mem_wdata_o, cur.we, cur.addr, cur.wdata);
          end
          waitCnt++;
          if (waitCnt >= memLat) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = cur.we ? 32'hBAD0_0BAD : memVal(mem_addr_o);
            busy        = 1'b0;
          end
        end
      end
    end
  end

  // Response scoreboard: every ack pulse must match the next expected transaction.
  initial begin : ackMonitor
    txnT e;
    forever begin
      @(negedge clk_i);
      if (iack_o === 1'b1 || dack_o === 1'b1) begin
        assertCnt++;
        if (ackQ.size() == 0) begin
          failCnt++;
          $display("FAIL unexpected_ack: got iack=%0b dack=%0b, required none", iack_o, dack_o);
        end else begin
          e = ackQ.pop_front();
          $display("ack  %s addr=%h irdata=%h drdata=%h", e.isData ? "D" : "I", e.addr, irdata_o, drdata_o);
          if ({iack_o, dack_o} !== {~e.isData, e.isData} ||
              (e.isData ? drdata_o : irdata_o) !== e.rdata) begin
            failCnt++;
            $display("FAIL ack_data: got iack=%0b dack=%0b ird=%h drd=%h, required %s data %h",
                     iack_o, dack_o, irdata_o, drdata_o, e.isData ? "dack" : "iack", e.rdata);
          end
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    ireq_i = 1'b1;
    #1;
    assertCnt++;
    if (stall_o !== 1'b0) begin
      failCnt++; $display("FAIL reset_stall: got %0b, required 0", stall_o);
    end
    assertCnt++;
    if ({mem_en_o, mem_we_o, iack_o, dack_o} !== 4'b0) begin
      failCnt++; $display("FAIL reset_ctrl: got %b, required 0000", {mem_en_o, mem_we_o, iack_o, dack_o});
    end
    assertCnt++;
    if ({mem_addr_o, mem_wdata_o, irdata_o, drdata_o} !== 128'h0) begin
      failCnt++; $display("FAIL reset_data: got %h %h %h %h, required all zero", mem_addr_o, mem_wdata_o, irdata_o, drdata_o);
    end
`ifdef ARB_PERF_CNT_EN
    assertCnt++;
    if (stallCnt !== 32'h0 || conflictCnt !== 16'h0) begin
      failCnt++; $display("FAIL reset_perf: got %h %h, required 0 0", stallCnt, conflictCnt);
    end
`endif
    ireq_i = 1'b0;
    rst_i  = 1'b0;
    @(negedge clk_i); #1;
    assertCnt++;
    if (mem_en_o !== 1'b0) begin
      failCnt++; $display("FAIL idle_en: got %0b, required 0", mem_en_o);
    end
  endtask

  task automatic test_fetch();
    int ackAt;
    ackAt  = -1;
    memLat = 2;
    @(posedge clk_i); #1;
    iReqQ.push_back(32'h0000_0040);
    expect_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i); #1;
      if (iack_o === 1'b1) begin
        ackAt = c;
        break;
      end
      assertCnt++;
      if (stall_o !== 1'b1) begin
        failCnt++; $display("FAIL fetch_stall: cycle %0d got %0b, required 1", c, stall_o);
      end
    end
    assertCnt++;
    if (ackAt != memLat + 1) begin
      failCnt++; $display("FAIL fetch_latency: got %0d, required %0d", ackAt, memLat + 1);
    end
    @(negedge clk_i); #1;
    assertCnt++;
    if ({iack_o, mem_en_o, stall_o} !== 3'b000) begin
      failCnt++; $display("FAIL fetch_after: got iack/en/stall=%b, required 000", {iack_o, mem_en_o, stall_o});
    end
  endtask

  task automatic test_store();
    reqT r;
    int  c;
    memLat = 3;
    @(posedge clk_i); #1;
    r.we = 1'b0; r.addr = 32'h20; r.wdata = 32'h0;
    dReqQ.push_back(r);
    expect_txn(1'b1, 1'b0, r.addr, r.wdata);
    r.we = 1'b1; r.addr = 32'h10; r.wdata = 32'hDEAD_BEEF;
    dReqQ.push_back(r);
    expect_txn(1'b1, 1'b1, r.addr, r.wdata);
    for (c = 0; c < 100 && ackQ.size() != 0; c++) @(negedge clk_i);
    assertCnt++;
    if (ackQ.size() != 0) begin
      failCnt++; $display("FAIL store_drain: got %0d pending, required 0", ackQ.size());
      ackQ.delete(); cmdQ.delete();
    end
    repeat (2) @(negedge clk_i);
    #1;
    assertCnt++;
    if (drdata_o !== lastDrdata) begin
      failCnt++; $display("FAIL store_drdata: got %h, required %h", drdata_o, lastDrdata);
    end
  endtask

  task automatic test_conflict();
    reqT r;
    int  c;
    int  stallSeen;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] stallStart;
    logic [15:0] conflictStart;
`endif
    stallSeen = 0;
    memLat    = 1;
    @(posedge clk_i); #1;
`ifdef ARB_PERF_CNT_EN
    stallStart    = stallCnt;
    conflictStart = conflictCnt;
`endif
    r.we = 1'b0; r.addr = 32'h30; r.wdata = 32'h1111_2222;
    dReqQ.push_back(r);
    iReqQ.push_back(32'h44);
    expect_txn(1'b1, 1'b0, 32'h30, 32'h1111_2222);
    expect_txn(1'b0, 1'b0, 32'h44, 32'h0);
    for (c = 0; c < 100 && ackQ.size() != 0; c++) begin
      @(negedge clk_i); #1;
      if (stall_o === 1'b1) stallSeen++;
    end
    assertCnt++;
    if (ackQ.size() != 0) begin
      failCnt++; $display("FAIL conflict_drain: got %0d pending, required 0", ackQ.size());
      ackQ.delete(); cmdQ.delete();
    end
    repeat (3) begin
      @(negedge clk_i); #1;
      if (stall_o === 1'b1) stallSeen++;
    end
    assertCnt++;
    if (stallSeen != 5) begin
      failCnt++; $display("FAIL conflict_stall_cycles: got %0d, required 5", stallSeen);
    end
`ifdef ARB_PERF_CNT_EN
    assertCnt++;
    if (stallCnt - stallStart !== 32'(stallSeen)) begin
      failCnt++; $display("FAIL perf_stall_cnt: got %0d, required %0d", stallCnt - stallStart, stallSeen);
    end
    assertCnt++;
    if (conflictCnt - conflictStart !== 16'd1) begin
      failCnt++; $display("FAIL perf_conflict_cnt: got %0d, required 1", conflictCnt - conflictStart);
    end
`endif
  endtask

  task automatic test_starvation();
    reqT r;
    int  nD, sc, di, c, dBefore;
    bit  iPending, iSeen;
    nD = 6; sc = 0; di = 0; dBefore = 0;
    iPending = 1'b1; iSeen = 1'b0;
    memLat = 1;
    @(posedge clk_i); #1;
    for (int k = 0; k < nD; k++) begin
      r.we = 1'b0; r.addr = 32'h100 + 32'(4 * k); r.wdata = 32'hC0DE_0000 + 32'(k);
      dReqQ.push_back(r);
    end
    iReqQ.push_back(32'h200);
    while (di < nD || iPending) begin
      if (di < nD && !(iPending && sc == STARVE_LIMIT)) begin
        expect_txn(1'b1, 1'b0, 32'h100 + 32'(4 * di), 32'hC0DE_0000 + 32'(di));
        sc = iPending ? ((sc == STARVE_LIMIT) ? sc : sc + 1) : 0;
        di++;
      end else begin
        expect_txn(1'b0, 1'b0, 32'h200, 32'h0);
        sc = 0;
        iPending = 1'b0;
      end
    end
    for (c = 0; c < 200 && ackQ.size() != 0; c++) begin
      @(negedge clk_i); #1;
      if (dack_o === 1'b1 && !iSeen) dBefore++;
      if (iack_o === 1'b1) iSeen = 1'b1;
    end
    assertCnt++;
    if (ackQ.size() != 0) begin
      failCnt++; $display("FAIL starve_drain: got %0d pending, required 0", ackQ.size());
      ackQ.delete(); cmdQ.delete();
    end
    assertCnt++;
    if (dBefore != STARVE_LIMIT) begin
      failCnt++; $display("FAIL starve_grants_before_fetch: got %0d, required %0d", dBefore, STARVE_LIMIT);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset_mid_op();
    int c;
    memAuto = 1'b0;
    @(negedge clk_i);
    dreq_i = 1'b1; dwe_i = 1'b0; daddr_i = 32'h80; dwdata_i = 32'h0;
    @(negedge clk_i); #1;
    assertCnt++;
    if (mem_en_o !== 1'b1 || mem_addr_o !== 32'h80) begin
      failCnt++; $display("FAIL midop_busy: got en=%0b addr=%h, required 1 00000080", mem_en_o, mem_addr_o);
    end
    rst_i = 1'b1;
    #1;
    assertCnt++;
    if (stall_o !== 1'b0) begin
      failCnt++; $display("FAIL midop_reset_stall: got %0b, required 0", stall_o);
    end
    @(negedge clk_i); #1;
    assertCnt++;
    if (mem_en_o !== 1'b0 || dack_o !== 1'b0) begin
      failCnt++; $display("FAIL midop_abort: got en=%0b dack=%0b, required 0 0", mem_en_o, dack_o);
    end
    rst_i = 1'b0; dreq_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_0000;
    @(negedge clk_i); #1;
    mem_ack_i = 1'b0;
    repeat (2) begin
      assertCnt++;
      if ({mem_en_o, dack_o, iack_o} !== 3'b000 || drdata_o !== 32'h0) begin
        failCnt++; $display("FAIL midop_late_ack: got en/dack/iack=%b drdata=%h, required 000 0",
                            {mem_en_o, dack_o, iack_o}, drdata_o);
      end
      @(negedge clk_i); #1;
    end
    lastDrdata = 32'h0;
    memAuto = 1'b1;
    @(posedge clk_i); #1;
    iReqQ.push_back(32'h0000_0040);
    expect_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    for (c = 0; c < 50 && ackQ.size() != 0; c++) @(negedge clk_i);
    assertCnt++;
    if (ackQ.size() != 0) begin
      failCnt++; $display("FAIL midop_recover: got %0d pending, required 0", ackQ.size());
      ackQ.delete(); cmdQ.delete();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    ireq_i = 1'b0; iaddr_i = 32'h0;
    dreq_i = 1'b0; dwe_i = 1'b0; daddr_i = 32'h0; dwdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    test_reset();
    test_fetch();
    test_store();
    test_conflict();
    test_starvation();
    test_reset_mid_op();
    repeat (3) @(negedge clk_i);
    assertCnt++;
    if (cmdQ.size() != 0) begin
      failCnt++; $display("FAIL leftover_cmds: got %0d, required 0", cmdQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store from the EX/MEM pipeline register).
- Serialises accesses through a small FSM and holds the memory command stable until the memory acknowledges.
- Returns read data and a one-cycle ack to the winning requester.
- Drives stall_o, which freezes the PC and all pipeline registers while any access is outstanding.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- STARVE_LIMIT, 4, maximum consecutive data grants while an instruction request waits (range 1..15)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- ireq_i  in  1  fetch request; held until iack_o
- iaddr_i  in  ADDR_W  fetch address
- irdata_o  out  DATA_W  fetched instruction; valid while iack_o=1
- iack_o  out  1  one-cycle fetch completion pulse
- dreq_i  in  1  data request (MemRead|MemWrite of EX/MEM); held until dack_o
- dwe_i  in  1  1 = store, 0 = load
- daddr_i  in  ADDR_W  data address (ALU result)
- dwdata_i  in  DATA_W  store data (RT data)
- drdata_o  out  DATA_W  load data; valid while dack_o=1
- dack_o  out  1  one-cycle data completion pulse
- mem_en_o  out  1  memory command valid
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data; sampled with mem_ack_i
- mem_ack_i  in  1  memory completion, one cycle
- stall_o  out  1  pipeline freeze

Behaviour:
- Reset (rst_i=1 at a rising edge): state=IDLE and starve_cnt=0. All registered outputs (mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, irdata_o, drdata_o, iack_o, dack_o) are 0.
- Reset during IBUSY/DBUSY abandons the transaction: mem_en_o=0 on the next cycle and no ack is issued.
- State IDLE:
  - dreq_i and not (ireq_i and starve_cnt==STARVE_LIMIT): latch daddr/dwe/dwdata into the mem_* registers, mem_en_o<=1, go to DBUSY.
  - else if ireq_i: latch iaddr, mem_we_o<=0, mem_wdata_o<=0, mem_en_o<=1, go to IBUSY.
  - else: stay in IDLE.
- Arbitration: data has priority (it is the older instruction). Fairness is enforced through starve_cnt:
  - D grant with ireq_i=1: starve_cnt increments, saturating at STARVE_LIMIT.
  - Any I grant, or a D grant with ireq_i=0: starve_cnt clears.
- State IBUSY/DBUSY:
  - mem_en_o and the mem_* registers are held constant.
  - On mem_ack_i=1: mem_en_o<=0, go to RESP. A read captures mem_rdata_i into irdata_o or drdata_o. A store leaves drdata_o unchanged.
  - The matching iack_o or dack_o is 1 for exactly the RESP cycle.
- State RESP: acks are 1 for this cycle only; go to IDLE. A requester sees its ack and may drop or change its request from the next cycle. IDLE therefore never re-serves a completed request.
- mem_ack_i in IDLE or RESP is ignored.
- Latency: request seen in IDLE at cycle 0, mem_en_o=1 from cycle 1, mem_ack_i at cycle k≥1, ack pulse at cycle k+1, IDLE at k+2. Minimum round trip is 3 cycles.
- stall_o is combinational: (dreq_i & ~dack_o) | (ireq_i & ~iack_o). It is 0 during reset.
- Requests asserted during BUSY/RESP are held by the requester and arbitrated in the next IDLE.
- The request is sampled only in IDLE. Address/data changes during BUSY have no effect.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined, adds two outputs, both cleared by rst_i:
  - stall_cnt_o [31:0]: increments each cycle stall_o=1, wraps.
  - conflict_cnt_o [15:0]: increments each IDLE cycle with ireq_i=dreq_i=1, saturates at 16'hFFFF.
- When undefined, neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- Fetch only: ireq_i=1, iaddr_i=32'h0000_0040; memory acks 2 cycles after mem_en_o with 32'h2002_0005 -> mem_addr_o=32'h40, mem_we_o=0, iack_o pulses once with irdata_o=32'h2002_0005; stall_o=1 until the ack cycle.
- Store: dreq_i=1, dwe_i=1, daddr_i=32'h10, dwdata_i=32'hDEAD_BEEF -> mem_we_o=1, mem_wdata_o=32'hDEAD_BEEF held until mem_ack_i; dack_o pulses once; drdata_o is unchanged.
- Conflict: ireq_i and dreq_i raised in the same cycle -> data is served first, then the fetch; two separate acks; no mem_en_o overlap.
- Starvation: dreq_i re-raised immediately after each ack, ireq_i held, STARVE_LIMIT=4 -> the 5th grant goes to the fetch, then data resumes.
- Reset mid-op: rst_i=1 for one cycle during DBUSY -> next cycle mem_en_o=0, no dack_o, state IDLE; a late mem_ack_i is ignored.
- ARB_PERF_CNT_EN: the conflict scenario with a 1-cycle memory -> conflict_cnt_o=1 and stall_cnt_o equals the counted stall_o-high cycles.
